board_ctrl: RTL and testbench
=============================

Name: board_ctrl

Overview:
- Parametrised N×N two-player board controller for the game datapath.
- Drives cursor movement and mark placement from the `move` and `select` buttons.
- Checks for a win or draw after every placement, using a sequential line scan.
- Exposes the board through a combinational read port for the VGA renderer and 7-segment decoders.
- Successor to the fixed 16-cell game logic: board size is generic, win/draw detection is built in, and restart works without reset.

Parameters:
- N, 4: board side length; legal range 3–8.
- NCELL, N*N: derived cell count; not overridable.
- AW, $clog2(NCELL): width of cell addresses.
- MW, $clog2(NCELL+1): width of the move counter.

Ports:
- clk  in  1  system clock (the divided game clock at top level)
- rst  in  1  reset, synchronous, active-low
- move  in  1  cursor-advance button; active-high, already synchronised
- select  in  1  place/restart button; active-high, already synchronised
- rd_addr  in  AW  VGA read address, row-major (addr = row*N+col)
- rd_cell  out  2  cell contents at rd_addr; combinational
- cursor  out  AW  current cursor cell
- player  out  1  side to move; 0 = P1, 1 = P2
- move_count  out  MW  number of marks placed
- state  out  2  0 = PLAY, 1 = CHECK, 2 = OVER
- winner  out  2  0 = none, 1 = P1, 2 = P2, 3 = draw
- occ_err  out  1  one-cycle pulse when select hits an occupied cell

Behaviour:
- Reset is synchronous and active-low: on any clk edge with rst = 0, all state is cleared.
  - Every cell is set to 0 (empty).
  - cursor = 0, player = 0, move_count = 0, winner = 0, occ_err = 0, state = PLAY.
  - The edge-detector history registers are cleared.
  - Reset mid-CHECK abandons the scan; the placed mark is lost.
- Cell encoding: 0 = empty, 1 = P1, 2 = P2; value 3 is never written.
- Button edges:
  - move_r and select_r are rising edges: `in & ~prev`, with `prev` registered every cycle in every state.
  - A button held high therefore yields exactly one event.
- PLAY state:
  - move_r alone: cursor <= (cursor == NCELL-1) ? 0 : cursor+1.
  - select_r on an empty cursor cell:
    - the cell is written with player+1;
    - the row/column of the cursor are latched into lr/lc;
    - move_count increments;
    - k <= 0 and state <= CHECK.
  - select_r on an occupied cell: occ_err = 1 for exactly the next cycle; board, player and state are unchanged.
  - move_r and select_r in the same cycle: select wins and move is dropped (the cursor does not advance).
- CHECK state (exactly N cycles, k = 0 .. N-1):
  - Four flags start at 1 on entry and are AND-ed each cycle:
    - row: cell(lr,k) == mark
    - column: cell(k,lc) == mark
    - diagonal: cell(k,k) == mark
    - anti-diagonal: cell(k,N-1-k) == mark
  - The diagonal counts only if lr == lc; the anti-diagonal counts only if lr+lc == N-1.
  - On the k = N-1 cycle, the result includes that cycle's compares:
    - any valid flag true: winner <= player+1, state <= OVER, player is not toggled;
    - else if move_count == NCELL: winner <= 3, state <= OVER;
    - else: player toggles and state <= PLAY.
  - move/select edges are ignored during CHECK.
- Latency: result is visible N+1 clocks after the select_r cycle.
  - The write and the CHECK entry occur on the first edge.
  - The outcome is registered on edge N+1.
- OVER state:
  - move_r is ignored.
  - select_r clears all cells and returns to PLAY in one edge, with cursor, move_count and winner set to 0.
  - The loser (player toggled) moves first. After a draw, player also toggles.
- rd_cell reflects the write on the cycle after the write edge. Out-of-range rd_addr (≥ NCELL) returns 0.
- move_count never exceeds NCELL: a full board always ends the game in CHECK.

Decomposition:
- Package board_pkg holds:
  - typedef cell_t as a 2-bit enum: EMPTY, P1, P2;
  - typedef state_t: PLAY, CHECK, OVER;
  - winner codes: W_NONE, W_P1, W_P2, W_DRAW.
- Sub-module edge_rise (clk, rst, in, pulse) is instantiated once for move and once for select.
- The board is a flat array of NCELL cell_t registers; no RAM inference.

Test Plan:
- Reset and cursor wrap (N=4):
  - stimulus: hold rst=0 for 2 cycles, release, then 17 move pulses;
  - response: cursor wraps 15→0 and ends at 1; all rd_cell reads are 0; state = PLAY.
- Row win (N=4):
  - stimulus: P1 marks cells 0,1,2,3 with P2 at 4,5,6;
  - response: after the 7th select state = CHECK for 4 cycles, then winner = 1 and state = OVER; move_count = 7.
- Anti-diagonal win (N=4):
  - stimulus: P2 takes 3,6,9,12 while P1 plays elsewhere;
  - response: winner = 2 after the P2 select on 12 plus 5 clocks.
- Occupied cell and simultaneous events:
  - stimulus: select on an already-marked cell;
  - response: occ_err pulses for 1 cycle and player/board are unchanged.
  - stimulus: move and select rising in the same cycle;
  - response: placement occurs and cursor is unchanged.
- Draw and restart (N=3):
  - stimulus: fill a 9-move no-win board;
  - response: winner = 3, move_count = 9.
  - stimulus: select in OVER;
  - response: board cleared, winner = 0, player toggled.
- Reset mid-CHECK and held button:
  - stimulus: assert rst on the 2nd CHECK cycle;
  - response: full reset values and the board is empty.
  - stimulus: hold select high for 10 cycles;
  - response: exactly one placement.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types for the board controller: cell contents, FSM states, winner codes.
// No logic, no latency.
// No flow control; consumers import the whole package.
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [1:0] W_NONE = 2'd0;
    localparam logic [1:0] W_P1   = 2'd1;
    localparam logic [1:0] W_P2   = 2'd2;
    localparam logic [1:0] W_DRAW = 2'd3;

endpackage

// File: rtl/board_if.sv
// Player-input / board-status bundle between the game datapath and the board controller.
// Wires only; every field is either a button level, a read address or a status view.
// No flow control: buttons are level inputs, status outputs are always valid.
//   move, select : synchronised buttons (active high)
//   rd_addr/rd_cell : combinational board read port (row-major)
//   cursor, player, move_count, state, winner, occ_err : game status
interface board_if #(parameter int N = 4) ();
    localparam int NCELL = N * N;
    localparam int AW    = $clog2(NCELL);
    localparam int MW    = $clog2(NCELL + 1);

    logic          move;
    logic          select;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_cell;
    logic [AW-1:0] cursor;
    logic          player;
    logic [MW-1:0] move_count;
    logic [1:0]    state;
    logic [1:0]    winner;
    logic          occ_err;

    modport master (
        output move, select, rd_addr,
        input  rd_cell, cursor, player, move_count, state, winner, occ_err
    );

    modport slave (
        input  move, select, rd_addr,
        output rd_cell, cursor, player, move_count, state, winner, occ_err
    );
endinterface

// File: rtl/board_ctrl_edge_rise.sv
// Rising-edge detector for an already-synchronised button level.
// Pulse is combinational in the first cycle the input is seen high; history updates every cycle.
// No flow control; a held button produces exactly one pulse.
//   clk, rst (sync, active low), in (level), pulse (one-cycle event)
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) prev <= 1'b0;
        else      prev <= in;
    end

    assign pulse = in & ~prev;
endmodule

// File: rtl/board_ctrl.sv
// N x N two-player board: cursor/placement FSM with a sequential N-cycle win/draw line scan.
// Placement written on the select edge; outcome registered N clocks later (N+1 edges total).
// No flow control: button edges outside PLAY/OVER are dropped; read port is always valid.
//   clk, rst (sync, active low); bus = board_if.slave (buttons, read port, status)
module board_ctrl #(
    parameter int N = 4
) (
    input  logic   clk,
    input  logic   rst,
    board_if.slave bus
);
    import board_pkg::*;

    localparam int NCELL = N * N;
    localparam int AW    = $clog2(NCELL);
    localparam int MW    = $clog2(NCELL + 1);
    localparam int KW    = $clog2(N);

    cell_t         board [NCELL];
    state_t        state_q, state_d;
    logic [AW-1:0] cursor_q;
    logic          player_q;
    logic [MW-1:0] cnt_q;
    logic [1:0]    winner_q;
    logic          occ_q;
    logic [KW-1:0] lr_q, lc_q, k_q;
    logic          fr_q, fc_q, fd_q, fa_q;

    logic move_r, select_r;

    edge_rise u_move   (.clk(clk), .rst(rst), .in(bus.move),   .pulse(move_r));
    edge_rise u_select (.clk(clk), .rst(rst), .in(bus.select), .pulse(select_r));

    function automatic logic [AW-1:0] idx(input logic [KW-1:0] r, input logic [KW-1:0] c);
        return AW'(int'(r) * N + int'(c));
    endfunction

    cell_t mark;
    logic  fr_n, fc_n, fd_n, fa_n;
    logic  last_k, win;
    logic  do_move, do_place, do_occ, do_win, do_draw, do_next, do_clear;

    always_comb begin
        mark     = player_q ? P2 : P1;
        // Running line flags include this cycle's compare so the last scan
        // step decides on the complete line.
        fr_n     = fr_q && (board[idx(lr_q, k_q)] == mark);
        fc_n     = fc_q && (board[idx(k_q, lc_q)] == mark);
        fd_n     = fd_q && (board[idx(k_q, k_q)] == mark);
        fa_n     = fa_q && (board[idx(k_q, KW'(N - 1) - k_q)] == mark);
        last_k   = (k_q == KW'(N - 1));
        // Diagonals only count when the last mark actually lies on them.
        win      = fr_n || fc_n
                 || ((lr_q == lc_q) && fd_n)
                 || ((int'(lr_q) + int'(lc_q) == N - 1) && fa_n);

        state_d  = state_q;
        do_move  = 1'b0;
        do_place = 1'b0;
        do_occ   = 1'b0;
        do_win   = 1'b0;
        do_draw  = 1'b0;
        do_next  = 1'b0;
        do_clear = 1'b0;

        case (state_q)
            PLAY: begin
                // Select has priority; a simultaneous move edge is dropped.
                if (select_r) begin
                    if (board[cursor_q] == EMPTY) begin
                        do_place = 1'b1;
                        state_d  = CHECK;
                    end else begin
                        do_occ = 1'b1;
                    end
                end else if (move_r) begin
                    do_move = 1'b1;
                end
            end
            CHECK: begin
                if (last_k) begin
                    if (win) begin
                        do_win  = 1'b1;
                        state_d = OVER;
                    end else if (cnt_q == MW'(NCELL)) begin
                        do_draw = 1'b1;
                        state_d = OVER;
                    end else begin
                        do_next = 1'b1;
                        state_d = PLAY;
                    end
                end
            end
            OVER: begin
                if (select_r) begin
                    do_clear = 1'b1;
                    state_d  = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= PLAY;
            cursor_q <= '0;
            player_q <= 1'b0;
            cnt_q    <= '0;
            winner_q <= W_NONE;
            occ_q    <= 1'b0;
            lr_q     <= '0;
            lc_q     <= '0;
            k_q      <= '0;
            fr_q     <= 1'b0;
            fc_q     <= 1'b0;
            fd_q     <= 1'b0;
            fa_q     <= 1'b0;
            for (int i = 0; i < NCELL; i++) board[i] <= EMPTY;
        end else begin
            state_q <= state_d;
            occ_q   <= do_occ;

            if (do_move) cursor_q <= (cursor_q == AW'(NCELL - 1)) ? '0 : cursor_q + AW'(1);

            if (do_place) begin
                board[cursor_q] <= mark;
                lr_q  <= KW'(int'(cursor_q) / N);
                lc_q  <= KW'(int'(cursor_q) % N);
                cnt_q <= cnt_q + MW'(1);
                k_q   <= '0;
                fr_q  <= 1'b1;
                fc_q  <= 1'b1;
                fd_q  <= 1'b1;
                fa_q  <= 1'b1;
            end

            if (state_q == CHECK) begin
                k_q  <= k_q + KW'(1);
                fr_q <= fr_n;
                fc_q <= fc_n;
                fd_q <= fd_n;
                fa_q <= fa_n;
            end

            if (do_win)  winner_q <= player_q ? W_P2 : W_P1;
            if (do_draw) winner_q <= W_DRAW;

            // Winner keeps the move until restart, so the toggle there hands
            // the first move to the loser (or to the other side after a draw).
            if (do_next || do_clear) player_q <= ~player_q;

            if (do_clear) begin
                cursor_q <= '0;
                cnt_q    <= '0;
                winner_q <= W_NONE;
                for (int i = 0; i < NCELL; i++) board[i] <= EMPTY;
            end
        end
    end

    always_comb begin
        bus.rd_cell = EMPTY;
        if (int'(bus.rd_addr) < NCELL) bus.rd_cell = board[bus.rd_addr];
    end

    assign bus.cursor     = cursor_q;
    assign bus.player     = player_q;
    assign bus.move_count = cnt_q;
    assign bus.state      = state_q;
    assign bus.winner     = winner_q;
    assign bus.occ_err    = occ_q;
endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl: one N=4 and one N=3 instance driven by directed move sequences.
// Expected game outcomes and occupied-cell pulses are queued at issue; a monitor pops on DUT events.
// Static state (cursor, cells, reset values) is compared directly by the stimulus thread.
module tb_board_ctrl;

    typedef struct {
        int kind;   // 0 = placement outcome, 1 = occupied-cell pulse
        int st;
        int w;
        int pl;
        int cnt;
    } exp_t;

    typedef struct {
        int cur;
        int st;
        int pl;
        int cnt;
        int w;
        int occ;
    } obs_t;

    logic clk  = 1'b0;
    logic rst4 = 1'b0;
    logic rst3 = 1'b0;
    always #5 clk = ~clk;

    board_if #(.N(4)) if4 ();
    board_if #(.N(3)) if3 ();

    board_ctrl #(.N(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));
    board_ctrl #(.N(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3));

    int checks   = 0;
    int failures = 0;

    exp_t q4[$];
    exp_t q3[$];
    int   prev_st [2] = '{0, 0};
    int   chk_len [2] = '{0, 0};
    int   m_cur   [2] = '{0, 0};
    int   m_pl    [2] = '{0, 0};
    int   m_cnt   [2] = '{0, 0};

    // Directed move tables: cell index, expected winner after the scan, simultaneous move.
    int t2_c [7] = '{0, 4, 1, 5, 2, 6, 3};
    int t2_w [7] = '{0, 0, 0, 0, 0, 0, 1};
    int t3_c [7] = '{3, 0, 6, 1, 9, 2, 12};
    int t3_w [7] = '{0, 0, 0, 0, 0, 0, 2};
    bit t3_s [7] = '{0, 1, 0, 0, 0, 0, 0};
    int t5_c [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int t5_w [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 3};
    int t5_v [9] = '{1, 2, 1, 1, 2, 2, 2, 1, 1};   // final board, cells 0..8

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: DUT event with no matching scoreboard entry", nm);
    endtask

    function automatic obs_t get(input int d);
        obs_t o;
        if (d == 4) begin
            o.cur = int'(if4.cursor);  o.st = int'(if4.state);  o.pl  = int'(if4.player);
            o.cnt = int'(if4.move_count); o.w = int'(if4.winner); o.occ = int'(if4.occ_err);
        end else begin
            o.cur = int'(if3.cursor);  o.st = int'(if3.state);  o.pl  = int'(if3.player);
            o.cnt = int'(if3.move_count); o.w = int'(if3.winner); o.occ = int'(if3.occ_err);
        end
        return o;
    endfunction

    task automatic push(input int di, input exp_t e);
        if (di == 0) q4.push_back(e);
        else         q3.push_back(e);
    endtask

    task automatic pop(input int di, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{-1, 0, 0, 0, 0};
        if (di == 0 && q4.size() > 0) begin e = q4.pop_front(); ok = 1'b1; end
        if (di == 1 && q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
    endtask

    task automatic drv(input int d, input logic mv, input logic sel);
        if (d == 4) begin if4.move = mv; if4.select = sel; end
        else        begin if3.move = mv; if3.select = sel; end
    endtask

    task automatic pulse(input int d, input logic mv, input logic sel);
        @(negedge clk);
        drv(d, mv, sel);
        @(negedge clk);
        drv(d, 1'b0, 1'b0);
    endtask

    task automatic chk_cell(input int d, input int a, input int exp, input string nm);
        int v;
        if (d == 4) begin if4.rd_addr = a[3:0]; #1; v = int'(if4.rd_cell); end
        else        begin if3.rd_addr = a[3:0]; #1; v = int'(if3.rd_cell); end
        chk(nm, v, exp);
    endtask

    task automatic go_to(input int d, input int c);
        int di = (d == 4) ? 0 : 1;
        while (m_cur[di] != c) begin
            pulse(d, 1'b1, 1'b0);
            m_cur[di] = (m_cur[di] + 1) % (d * d);
        end
    endtask

    task automatic place(input int d, input int c, input int exp_w, input bit sim);
        int   di = (d == 4) ? 0 : 1;
        exp_t e;
        obs_t o;
        go_to(d, c);
        m_cnt[di]++;
        if (exp_w == 0) m_pl[di] = 1 - m_pl[di];
        e = '{0, (exp_w == 0) ? 0 : 2, exp_w, m_pl[di], m_cnt[di]};
        push(di, e);
        pulse(d, sim, 1'b1);
        o = get(d);
        chk("place_cursor", o.cur, c);
        chk("enter_check", o.st, 1);
        repeat (d + 1) @(negedge clk);
    endtask

    task automatic occ(input int d);
        int   di = (d == 4) ? 0 : 1;
        exp_t e;
        obs_t o;
        e = '{1, 0, 0, m_pl[di], m_cnt[di]};
        push(di, e);
        pulse(d, 1'b0, 1'b1);
        @(negedge clk);
        o = get(d);
        chk("occ_count_kept", o.cnt, m_cnt[di]);
        chk("occ_player_kept", o.pl, m_pl[di]);
        chk("occ_state_play", o.st, 0);
    endtask

    task automatic restart(input int d);
        int   di = (d == 4) ? 0 : 1;
        obs_t o;
        pulse(d, 1'b0, 1'b1);
        m_pl[di]  = 1 - m_pl[di];
        m_cnt[di] = 0;
        m_cur[di] = 0;
        o = get(d);
        chk("restart_state", o.st, 0);
        chk("restart_winner", o.w, 0);
        chk("restart_player", o.pl, m_pl[di]);
        chk("restart_count", o.cnt, 0);
        chk("restart_cursor", o.cur, 0);
        for (int a = 0; a < d * d; a++) chk_cell(d, a, 0, "restart_cell");
    endtask

    task automatic reset_vals(input int d, input string nm);
        obs_t o = get(d);
        chk({nm, "_cursor"}, o.cur, 0);
        chk({nm, "_state"},  o.st,  0);
        chk({nm, "_player"}, o.pl,  0);
        chk({nm, "_count"},  o.cnt, 0);
        chk({nm, "_winner"}, o.w,   0);
        chk({nm, "_occ"},    o.occ, 0);
    endtask

    task automatic monitor(input int d);
        int   di = (d == 4) ? 0 : 1;
        obs_t o;
        exp_t e;
        bit   ok;
        bit   r;
        o = get(d);
        r = (d == 4) ? rst4 : rst3;
        if (!r) begin
            prev_st[di] = o.st;
            chk_len[di] = 0;
            return;
        end
        if (o.occ != 0) begin
            pop(di, e, ok);
            if (!ok || e.kind != 1) fail_evt("occ_err_pulse");
            else begin
                chk("occ_evt_player", o.pl, e.pl);
                chk("occ_evt_state", o.st, e.st);
            end
        end
        if (prev_st[di] == 1 && o.st != 1) begin
            pop(di, e, ok);
            if (!ok || e.kind != 0) fail_evt("check_exit");
            else begin
                chk("result_state",  o.st,  e.st);
                chk("result_winner", o.w,   e.w);
                chk("result_player", o.pl,  e.pl);
                chk("result_count",  o.cnt, e.cnt);
                chk("check_cycles",  chk_len[di], d);
            end
        end
        chk_len[di] = (o.st == 1) ? chk_len[di] + 1 : 0;
        prev_st[di] = o.st;
    endtask

    always @(posedge clk) begin
        #1;
        monitor(4);
        monitor(3);
    end

    initial begin
        drv(4, 1'b0, 1'b0);
        drv(3, 1'b0, 1'b0);
        if4.rd_addr = '0;
        if3.rd_addr = '0;

        // Reset and cursor wrap
        repeat (2) @(negedge clk);
        rst4 = 1'b1;
        rst3 = 1'b1;
        reset_vals(4, "reset4");
        reset_vals(3, "reset3");
        for (int i = 0; i < 17; i++) begin
            obs_t o;
            pulse(4, 1'b1, 1'b0);
            m_cur[0] = (m_cur[0] + 1) % 16;
            o = get(4);
            chk("wrap_cursor", o.cur, m_cur[0]);
        end
        for (int a = 0; a < 16; a++) chk_cell(4, a, 0, "reset_cell");
        chk("wrap_state", get(4).st, 0);

        // Row win for P1
        for (int i = 0; i < 7; i++) place(4, t2_c[i], t2_w[i], 1'b0);
        for (int a = 0; a < 4; a++) chk_cell(4, a, 1, "row_p1_cell");
        for (int a = 4; a < 7; a++) chk_cell(4, a, 2, "row_p2_cell");
        chk_cell(4, 7, 0, "row_empty_cell");
        pulse(4, 1'b1, 1'b0);
        chk("over_move_ignored", get(4).cur, 3);
        chk("over_state_kept", get(4).st, 2);
        restart(4);

        // Anti-diagonal win for P2, with an occupied select and a move+select collision
        for (int i = 0; i < 7; i++) begin
            place(4, t3_c[i], t3_w[i], t3_s[i]);
            if (i == 0) begin
                occ(4);
                chk_cell(4, 3, 2, "occ_cell_kept");
            end
        end
        chk_cell(4, 12, 2, "anti_cell12");
        chk_cell(4, 0, 1, "sim_cell0");
        restart(4);

        // Reset on the second CHECK cycle abandons the placement
        pulse(4, 1'b0, 1'b1);
        chk("midchk_state", get(4).st, 1);
        @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        m_cur[0] = 0; m_pl[0] = 0; m_cnt[0] = 0;
        reset_vals(4, "midchk_reset");
        for (int a = 0; a < 16; a++) chk_cell(4, a, 0, "midchk_cell");

        // Select held high for 10 cycles places exactly once
        @(negedge clk);
        begin
            exp_t e = '{0, 0, 0, 1, 1};
            push(0, e);
        end
        if4.select = 1'b1;
        repeat (10) @(negedge clk);
        if4.select = 1'b0;
        @(negedge clk);
        chk("held_count", get(4).cnt, 1);
        chk("held_player", get(4).pl, 1);
        chk_cell(4, 0, 1, "held_cell0");
        chk_cell(4, 1, 0, "held_cell1");

        // Draw on the 3x3 board, out-of-range reads, restart
        for (int i = 0; i < 9; i++) place(3, t5_c[i], t5_w[i], 1'b0);
        for (int a = 0; a < 9; a++) chk_cell(3, a, t5_v[a], "draw_cell");
        for (int a = 9; a < 16; a++) chk_cell(3, a, 0, "oob_cell");
        chk("draw_count", get(3).cnt, 9);
        restart(3);

        repeat (3) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
